// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control FSM: states, opcodes and datapath selects.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StExecI  = 4'd3,
        StAddr   = 4'd4,
        StBranch = 4'd5,
        StMemRd  = 4'd6,
        StMemWr  = 4'd7,
        StWbAlu  = 4'd8,
        StWbMem  = 4'd9,
        StHalt   = 4'd10
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    function automatic logic is_mem_state(state_t s);
        return (s == StFetch) || (s == StMemRd) || (s == StMemWr);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts consecutive cycles a memory state waits on mem_ready; flags expiry at MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned CNT_BITS = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CNT_BITS-1:0] cnt_q;

    // Any non-waiting cycle (ready or another state) clears the count, so each entry starts at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (waiting && (MEM_TIMEOUT != 0)) begin
            cnt_q <= cnt_q + CNT_BITS'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign expired = (MEM_TIMEOUT != 0) && waiting && (cnt_q == CNT_BITS'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with shared-memory handshake and retire counter.
// Optional illegal-opcode trap enabled by defining MCCU_ILLEGAL_TRAP_EN.
module multicycle_control_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_write,
    output logic               iord,
    output logic               ir_write,
    output logic               pc_write,
    output logic               pc_src,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               mem_timeout,
    output logic [CNT_W-1:0]   instr_retired,
    output logic [3:0]         state_dbg
`ifdef MCCU_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_instr
`endif
);

    state_t             state_q, state_d;
    logic               store_q;
    logic               timeout_q;
    logic [CNT_W-1:0]   retired_q;
    logic               retire, set_timeout, set_illegal;
    logic               waiting, expired;
    logic [1:0]         alu_op_int;

    assign waiting = is_mem_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .waiting (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            store_q   <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                store_q <= opcode[5];
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
            if (retire) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_timeout = 1'b0;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op_int  = ALUOP_ADD;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;

        case (state_q)
            StFetch: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_d     = StHalt;
                end
            end
            StDecode: begin
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_RTYPE:          state_d = StExecR;
                    OP_ITYPE:          state_d = StExecI;
                    OP_LOAD, OP_STORE: state_d = StAddr;
                    OP_BRANCH:         state_d = StBranch;
                    default: begin
`ifdef MCCU_ILLEGAL_TRAP_EN
                        set_illegal = 1'b1;
                        state_d     = StHalt;
`else
                        retire  = 1'b1;
                        state_d = StFetch;
`endif
                    end
                endcase
            end
            StExecR: begin
                alu_src_a  = 1'b1;
                alu_op_int = ALUOP_RTYPE;
                state_d    = StWbAlu;
            end
            StExecI: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op_int = ALUOP_ITYPE;
                state_d    = StWbAlu;
            end
            StAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = store_q ? StMemWr : StMemRd;
            end
            StBranch: begin
                alu_src_a  = 1'b1;
                alu_op_int = ALUOP_SUB;
                pc_src     = 1'b1;
                pc_write   = zero;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StMemRd: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = StWbMem;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_d     = StHalt;
                end
            end
            StMemWr: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (expired) begin
                    set_timeout = 1'b1;
                    state_d     = StHalt;
                end
            end
            StWbAlu: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = StFetch;
            end
            StWbMem: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase

        // Reset forces every control output low so nothing partial reaches the datapath.
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            iord       = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_REG;
            alu_op_int = ALUOP_ADD;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
        end
    end

    assign alu_op        = ALUOP_W'(alu_op_int);
    assign mem_timeout   = timeout_q;
    assign instr_retired = retired_q;
    assign state_dbg     = state_q;

`ifdef MCCU_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (set_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = illegal_q;
`else
    logic unused_set_illegal;
    assign unused_set_illegal = set_illegal;
`endif

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multi-cycle successor to the single-cycle opcode decoder.
- Sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared instruction/data memory with a ready handshake.
- Drives datapath mux selects and write enables, and counts retired instructions.
- Sits between the instruction register opcode field and the multi-cycle datapath (PC, IR, A/B, ALUOut, MDR registers).

Parameters:
- ALUOP_W, 2, width of alu_op. Must be ≥2; upper bits are zero.
- CNT_W, 32, width of the retired-instruction counter.
- MEM_TIMEOUT, 0, max cycles to wait on mem_ready. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  IR[6:0]. Sampled in DECODE only.
- zero  in  1  ALU zero flag. Sampled in BRANCH.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a write (valid with mem_req).
- iord  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut.
- alu_src_a  out  1  0=PC, 1=rs1 register A.
- alu_src_b  out  2  00=B, 01=const 4, 10=immediate.
- alu_op  out  ALUOP_W  00=add, 01=sub/compare, 10=R-type funct decode, 11=I-type funct decode.
- reg_write  out  1  register-file write enable.
- mem_to_reg  out  1  writeback source: 0=ALUOut, 1=MDR.
- mem_timeout  out  1  sticky flag: memory wait exceeded MEM_TIMEOUT.
- instr_retired  out  CNT_W  retired-instruction count.
- state_dbg  out  4  current state encoding.

Behaviour:
- Reset (async, rst=1):
  - state=FETCH, instr_retired=0, mem_timeout=0.
  - While rst is high, all outputs are forced 0 (including mem_req).
  - Reset mid-instruction abandons it. No partial register or memory write is issued after rst asserts.
- State encodings:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, BRANCH=5, MEM_RD=6, MEM_WR=7, WB_ALU=8, WB_MEM=9, HALT=10.
- FETCH:
  - Drives mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
  - Holds until mem_ready. In the mem_ready cycle, ir_write=1 and pc_write=1 (PC+4), then go to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → ADDR
    - 1100011 → BRANCH
    - any other opcode: see Optional Feature.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11, then WB_ALU.
- ADDR:
  - alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state is MEM_RD for a load, MEM_WR for a store. Opcode bit 5 is latched in DECODE for this choice.
- MEM_RD:
  - mem_req=1, iord=1. Wait for mem_ready (MDR loads), then WB_MEM.
- MEM_WR:
  - mem_req=1, mem_write=1, iord=1. Wait for mem_ready, then FETCH (retire).
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero.
  - Then FETCH (retire). Only BEQ semantics; funct3 is ignored.
- WB_ALU: reg_write=1, mem_to_reg=0, then FETCH (retire).
- WB_MEM: reg_write=1, mem_to_reg=1, then FETCH (retire).
- Retire:
  - instr_retired increments by 1 on every transition into FETCH from MEM_WR, BRANCH, WB_ALU or WB_MEM.
  - The counter wraps modulo 2^CNT_W.
- Latency with mem_ready tied high:
  - R/I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each wait cycle adds exactly 1 cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter resets on entry to each memory state.
  - When it reaches MEM_TIMEOUT without mem_ready: set mem_timeout and go to HALT.
- HALT:
  - All enables are 0. Held until reset. The counter freezes.

Optional Feature:
- Macro: MCCU_ILLEGAL_TRAP_EN.
- Defined:
  - An unrecognised opcode in DECODE goes to HALT.
  - An extra output illegal_instr (1 bit) is set sticky until reset.
  - The instruction does not retire.
- Undefined:
  - An unrecognised opcode goes from DECODE straight to FETCH as a NOP.
  - It retires (counter increments) with no register or memory write.
  - There is no illegal_instr port.

Decomposition:
- Package multicycle_ctrl_pkg holds:
  - the state encodings;
  - opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - the alu_op and alu_src_b encodings.
- One sub-module, mem_wait_timer: the wait counter with MEM_TIMEOUT compare, reused for fetch and data accesses.

Test Plan:
- R-type 0110011, mem_ready=1:
  - States 0→1→2→8→0.
  - reg_write=1 only in cycle 4.
  - instr_retired 0→1.
- Load 0000011 with mem_ready low for 2 cycles in MEM_RD:
  - Total latency 7 cycles.
  - mem_req held with iord=1 throughout the wait.
  - mem_to_reg=1 in WB_MEM.
- Branch 1100011:
  - With zero=1: pc_write=1 and pc_src=1 in BRANCH.
  - With zero=0: pc_write=0.
  - Both cases take 3 cycles and retire.
- Store with rst asserted during MEM_WR:
  - All outputs go 0 immediately.
  - After release, state=FETCH and instr_retired=0.
- MEM_TIMEOUT=3 with mem_ready stuck low in FETCH:
  - mem_timeout=1 after 3 cycles.
  - state=HALT, held until reset.
- Opcode 1111111:
  - With MCCU_ILLEGAL_TRAP_EN: HALT, illegal_instr=1, count unchanged.
  - Without it: FETCH after DECODE, count +1, no writes.
